// File: rtl/leaf_nn_scan_if.sv
// Bundle of the query, leaf-SRAM and result handshakes for leaf_nn_scan.
// The result_index2/result_dist2 pair only exists when LEAF_NN_SECOND_BEST_EN is defined.
interface leaf_nn_scan_if #(
  parameter int PATCH_WIDTH     = 55,
  parameter int ADDRESS_WIDTH   = 8,
  parameter int LEAF_SLOTS_LOG2 = 3,
  parameter int DIST_WIDTH      = 25
);
  localparam int IDX_W = ADDRESS_WIDTH + LEAF_SLOTS_LOG2;

  logic                     query_valid;
  logic                     query_ready;
  logic [ADDRESS_WIDTH-1:0] query_leaf;
  logic [PATCH_WIDTH-1:0]   query_patch;

  logic                     mem_ren;
  logic [IDX_W-1:0]         mem_addr;
  logic [PATCH_WIDTH-1:0]   mem_rdata;

  logic                     result_valid;
  logic                     result_ready;
  logic [IDX_W-1:0]         result_index;
  logic [DIST_WIDTH-1:0]    result_dist;
`ifdef LEAF_NN_SECOND_BEST_EN
  logic [IDX_W-1:0]         result_index2;
  logic [DIST_WIDTH-1:0]    result_dist2;
`endif

  modport slave (
    input  query_valid, query_leaf, query_patch, mem_rdata, result_ready,
    output query_ready, mem_ren, mem_addr, result_valid, result_index, result_dist
`ifdef LEAF_NN_SECOND_BEST_EN
    , output result_index2, output result_dist2
`endif
  );

  modport master (
    output query_valid, query_leaf, query_patch, mem_rdata, result_ready,
    input  query_ready, mem_ren, mem_addr, result_valid, result_index, result_dist
`ifdef LEAF_NN_SECOND_BEST_EN
    , input result_index2, input result_dist2
`endif
  );
endinterface

// File: rtl/leaf_nn_scan.sv
// Leaf nearest-neighbour scan: accepts a query patch and leaf index, reads the
// leaf's 8 candidate patches from SRAM, and reports the candidate with the
// smallest squared-L2 distance (lowest slot wins ties).
// Optional feature macro: LEAF_NN_SECOND_BEST_EN adds the runner-up result.
module leaf_nn_scan #(
  parameter int PATCH_WIDTH     = 55,
  parameter int ADDRESS_WIDTH   = 8,
  parameter int LEAF_SLOTS_LOG2 = 3,
  parameter int DIST_WIDTH      = 25
) (
  input  logic          clk,
  input  logic          rst_n,
  leaf_nn_scan_if.slave bus
);
  localparam int NCOMP  = 5;
  localparam int COMP_W = PATCH_WIDTH / NCOMP;
  localparam int SQ_W   = 2 * COMP_W;
  localparam logic [LEAF_SLOTS_LOG2-1:0] SLOT_LAST = {LEAF_SLOTS_LOG2{1'b1}};

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, HOLD} state_t;

  // Squared difference of one component: widen by one bit so the difference
  // cannot wrap, then square its magnitude as an unsigned number.
  function automatic logic [SQ_W-1:0] comp_sq(input logic signed [COMP_W-1:0] a,
                                               input logic signed [COMP_W-1:0] b);
    logic signed [COMP_W:0] d;
    logic        [COMP_W:0] mag;
    d   = {a[COMP_W-1], a} - {b[COMP_W-1], b};
    mag = d[COMP_W] ? (~d + 1'b1) : d;
    return SQ_W'(mag[COMP_W-1:0]) * SQ_W'(mag[COMP_W-1:0]);
  endfunction

  // Full squared-L2 distance; DIST_WIDTH holds five worst-case squares.
  function automatic logic [DIST_WIDTH-1:0] patch_dist(input logic [PATCH_WIDTH-1:0] q,
                                                       input logic [PATCH_WIDTH-1:0] c);
    logic [DIST_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < NCOMP; i++)
      acc = acc + DIST_WIDTH'(comp_sq(q[i*COMP_W +: COMP_W], c[i*COMP_W +: COMP_W]));
    return acc;
  endfunction

  state_t                     state_q, state_d;
  logic [LEAF_SLOTS_LOG2-1:0] slot_q, slot_d;
  logic [ADDRESS_WIDTH-1:0]   leaf_q, leaf_d;
  logic [PATCH_WIDTH-1:0]     patch_q, patch_d;

  logic                       vld_p0_q, vld_p0_d;
  logic [LEAF_SLOTS_LOG2-1:0] slot_p0_q, slot_p0_d;
  logic                       vld_p1_q, vld_p1_d;
  logic [LEAF_SLOTS_LOG2-1:0] slot_p1_q, slot_p1_d;
  logic [DIST_WIDTH-1:0]      dist_p1_q, dist_p1_d;

  logic [DIST_WIDTH-1:0]      best_dist_q, best_dist_d;
  logic [LEAF_SLOTS_LOG2-1:0] best_slot_q, best_slot_d;
`ifdef LEAF_NN_SECOND_BEST_EN
  logic [DIST_WIDTH-1:0]      sec_dist_q, sec_dist_d;
  logic [LEAF_SLOTS_LOG2-1:0] sec_slot_q, sec_slot_d;
  logic                       sec_vld_q, sec_vld_d;
`endif

  // Control FSM: accept in IDLE, issue 8 reads in SCAN, wait for the
  // pipeline to finish slot 7 in DRAIN, present the result in HOLD.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    leaf_d  = leaf_q;
    patch_d = patch_q;
    case (state_q)
      IDLE: begin
        if (bus.query_valid) begin
          leaf_d  = bus.query_leaf;
          patch_d = bus.query_patch;
          slot_d  = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        slot_d = slot_q + 1'b1;
        if (slot_q == SLOT_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (vld_p1_q && (slot_p1_q == SLOT_LAST)) state_d = HOLD;
      end
      HOLD: begin
        if (bus.result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: p0 marks the cycle read data is valid, p1 holds the registered
  // distance, and the best/second trackers consume p1.
  always_comb begin
    vld_p0_d    = (state_q == SCAN);
    slot_p0_d   = slot_q;
    vld_p1_d    = vld_p0_q;
    slot_p1_d   = slot_p0_q;
    dist_p1_d   = vld_p0_q ? patch_dist(patch_q, bus.mem_rdata) : dist_p1_q;
    best_dist_d = best_dist_q;
    best_slot_d = best_slot_q;
`ifdef LEAF_NN_SECOND_BEST_EN
    sec_dist_d  = sec_dist_q;
    sec_slot_d  = sec_slot_q;
    sec_vld_d   = sec_vld_q;
`endif
    if (vld_p1_q) begin
      if ((slot_p1_q == '0) || (dist_p1_q < best_dist_q)) begin
        best_dist_d = dist_p1_q;
        best_slot_d = slot_p1_q;
`ifdef LEAF_NN_SECOND_BEST_EN
        sec_dist_d  = best_dist_q;
        sec_slot_d  = best_slot_q;
        sec_vld_d   = (slot_p1_q != '0);
      end else if (!sec_vld_q || (dist_p1_q < sec_dist_q)) begin
        sec_dist_d  = dist_p1_q;
        sec_slot_d  = slot_p1_q;
        sec_vld_d   = 1'b1;
`endif
      end
    end
  end

  // State and pipeline registers; reset clears everything and aborts a query.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      leaf_q      <= '0;
      patch_q     <= '0;
      vld_p0_q    <= 1'b0;
      slot_p0_q   <= '0;
      vld_p1_q    <= 1'b0;
      slot_p1_q   <= '0;
      dist_p1_q   <= '0;
      best_dist_q <= '0;
      best_slot_q <= '0;
`ifdef LEAF_NN_SECOND_BEST_EN
      sec_dist_q  <= '0;
      sec_slot_q  <= '0;
      sec_vld_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      leaf_q      <= leaf_d;
      patch_q     <= patch_d;
      vld_p0_q    <= vld_p0_d;
      slot_p0_q   <= slot_p0_d;
      vld_p1_q    <= vld_p1_d;
      slot_p1_q   <= slot_p1_d;
      dist_p1_q   <= dist_p1_d;
      best_dist_q <= best_dist_d;
      best_slot_q <= best_slot_d;
`ifdef LEAF_NN_SECOND_BEST_EN
      sec_dist_q  <= sec_dist_d;
      sec_slot_q  <= sec_slot_d;
      sec_vld_q   <= sec_vld_d;
`endif
    end
  end

  assign bus.query_ready  = (state_q == IDLE);
  assign bus.mem_ren      = (state_q == SCAN);
  assign bus.mem_addr     = {leaf_q, slot_q};
  assign bus.result_valid = (state_q == HOLD);
  assign bus.result_index = {leaf_q, best_slot_q};
  assign bus.result_dist  = best_dist_q;
`ifdef LEAF_NN_SECOND_BEST_EN
  assign bus.result_index2 = {leaf_q, sec_slot_q};
  assign bus.result_dist2  = sec_dist_q;
`endif
endmodule

// File: tb/tb_leaf_nn_scan.sv
// Directed bench for leaf_nn_scan with a behavioural leaf SRAM.
// Covers LEAF_NN_SECOND_BEST_EN outputs when that macro is defined.
module tb_leaf_nn_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;

  leaf_nn_scan_if bus ();
  leaf_nn_scan dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [54:0] mem [0:2047];

  // Leaf SRAM: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [54:0] mkp(input int c0, input int c1, input int c2,
                                      input int c3, input int c4);
    return {c4[10:0], c3[10:0], c2[10:0], c1[10:0], c0[10:0]};
  endfunction

  // Starting #1 after the accepting edge: follow the scan, wait for the result.
  task automatic collect(input string t, input logic [7:0] leaf,
                         input logic [10:0] exp_idx, input logic [24:0] exp_dist);
    int lat, ren, addr_bad;
    logic [10:0] ea;
    lat = 0; ren = 0; addr_bad = 0;
    while (!bus.result_valid && lat < 40) begin
      if (bus.mem_ren) begin
        ea = {leaf, 3'(ren)};
        if (bus.mem_addr !== ea) addr_bad++;
        ren++;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk({t, "/latency"}, 64'(lat), 64'd10);
    chk({t, "/ren_cycles"}, 64'(ren), 64'd8);
    chk({t, "/addr_errors"}, 64'(addr_bad), 64'd0);
    chk({t, "/index"}, 64'(bus.result_index), 64'(exp_idx));
    chk({t, "/dist"}, 64'(bus.result_dist), 64'(exp_dist));
  endtask

  task automatic run_query(input string t, input logic [7:0] leaf, input logic [54:0] patch,
                           input logic [10:0] exp_idx, input logic [24:0] exp_dist);
    @(negedge clk);
    bus.query_valid = 1'b1;
    bus.query_leaf  = leaf;
    bus.query_patch = patch;
    @(posedge clk); #1;
    bus.query_valid = 1'b0;
    collect(t, leaf, exp_idx, exp_dist);
  endtask

  task automatic retire(input string t);
    @(negedge clk);
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    chk({t, "/retire_valid"}, 64'(bus.result_valid), 64'd0);
    chk({t, "/retire_ready"}, 64'(bus.query_ready), 64'd1);
  endtask

  initial begin
    int bad_v, bad_r, bad_q, bad_m, bad;
    for (int a = 0; a < 2048; a++) mem[a] = '0;
    for (int s = 0; s < 8; s++) begin
      mem[5*8 + s]    = mkp(s, s, s, s, s);
      mem[8'h12*8 + s] = (s == 3) ? mkp(2, 4, 0, 0, 0) :
                         (s == 6) ? mkp(0, 0, 4, 0, 2) :
                         (s == 0) ? mkp(5, 5, 5, 5, 5) : mkp(3, 3, 3, 3, -3);
      mem[8'hFF*8 + s] = mkp(1023, 1023, 1023, 1023, 1023);
      mem[8'h33*8 + s] = mkp(100 + (8 - s), -50 - (8 - s), 7, 0, -3);
    end
    bus.query_valid  = 1'b0;
    bus.query_leaf   = '0;
    bus.query_patch  = '0;
    bus.result_ready = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/query_ready", 64'(bus.query_ready), 64'd1);
    chk("rst/mem_ren", 64'(bus.mem_ren), 64'd0);
    chk("rst/mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst/result_valid", 64'(bus.result_valid), 64'd0);
    chk("rst/result_index", 64'(bus.result_index), 64'd0);
    chk("rst/result_dist", 64'(bus.result_dist), 64'd0);
`ifdef LEAF_NN_SECOND_BEST_EN
    chk("rst/result_index2", 64'(bus.result_index2), 64'd0);
    chk("rst/result_dist2", 64'(bus.result_dist2), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Exact match in slot 0 of leaf 5.
    run_query("t1", 8'h05, '0, 11'h028, 25'd0);
    retire("t1");

    // Equal distances in slots 3 and 6: lower slot wins.
    run_query("t2", 8'h12, '0, 11'h093, 25'd20);
`ifdef LEAF_NN_SECOND_BEST_EN
    chk("t2/index2", 64'(bus.result_index2), 64'h096);
    chk("t2/dist2", 64'(bus.result_dist2), 64'd20);
`endif
    retire("t2");

    // Extreme components on the all-ones leaf: largest possible distance.
    run_query("t3", 8'hFF, mkp(-1024, -1024, -1024, -1024, -1024), 11'h7F8, 25'd20951045);
`ifdef LEAF_NN_SECOND_BEST_EN
    chk("t3/index2", 64'(bus.result_index2), 64'h7F9);
    chk("t3/dist2", 64'(bus.result_dist2), 64'd20951045);
`endif
    retire("t3");

    // Every slot strictly closer than the last: best ends on slot 7.
    run_query("t4", 8'h33, mkp(100, -50, 7, 0, -3), 11'h19F, 25'd2);
`ifdef LEAF_NN_SECOND_BEST_EN
    chk("t4/index2", 64'(bus.result_index2), 64'h19E);
    chk("t4/dist2", 64'(bus.result_dist2), 64'd8);
`endif

    // Hold the result with a new query pending the whole time.
    @(negedge clk);
    bus.query_valid = 1'b1;
    bus.query_leaf  = 8'h12;
    bus.query_patch = '0;
    bad_v = 0; bad_r = 0; bad_q = 0; bad_m = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.result_valid !== 1'b1) bad_v++;
      if (bus.result_index !== 11'h19F || bus.result_dist !== 25'd2) bad_r++;
      if (bus.query_ready !== 1'b0) bad_q++;
      if (bus.mem_ren !== 1'b0) bad_m++;
    end
    chk("hold/valid_drop", 64'(bad_v), 64'd0);
    chk("hold/result_change", 64'(bad_r), 64'd0);
    chk("hold/query_ready", 64'(bad_q), 64'd0);
    chk("hold/mem_ren", 64'(bad_m), 64'd0);
    @(negedge clk);
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    chk("hold/retire_valid", 64'(bus.result_valid), 64'd0);
    chk("hold/retire_ready", 64'(bus.query_ready), 64'd1);
    chk("hold/retire_no_ren", 64'(bus.mem_ren), 64'd0);
    @(posedge clk); #1;
    bus.query_valid = 1'b0;
    chk("hold/next_accepted", 64'(bus.query_ready), 64'd0);
    collect("t5", 8'h12, 11'h093, 25'd20);
    retire("t5");

    // Reset during the 4th SCAN cycle aborts the query.
    @(negedge clk);
    bus.query_valid = 1'b1;
    bus.query_leaf  = 8'h33;
    bus.query_patch = mkp(100, -50, 7, 0, -3);
    @(posedge clk); #1;
    bus.query_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort/mem_ren", 64'(bus.mem_ren), 64'd0);
    chk("abort/mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("abort/result_valid", 64'(bus.result_valid), 64'd0);
    chk("abort/result_index", 64'(bus.result_index), 64'd0);
    chk("abort/result_dist", 64'(bus.result_dist), 64'd0);
    chk("abort/query_ready", 64'(bus.query_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.result_valid !== 1'b0 || bus.mem_ren !== 1'b0) bad++;
    end
    chk("abort/no_activity", 64'(bad), 64'd0);
    run_query("t6", 8'h05, '0, 11'h028, 25'd0);
    retire("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
